// File: rtl/sprite_tile_scheduler_if.sv
// sprite_tile_scheduler_if: sprite table, texture memory and pixel-array buses of the tile scheduler.
interface sprite_tile_scheduler_if #(parameter int SPR_AW = 4, parameter int TEX_AW = 12);
    logic [SPR_AW-1:0]    o_spr_addr;
    logic [TEX_AW+17:0]   i_spr_data;
    logic                 o_tex_req;
    logic [TEX_AW-1:0]    o_tex_addr;
    logic                 i_tex_ack;
    logic [127:0]         i_tex_data;
    logic                 o_sp_ena;
    logic [127:0]         o_sp_texture_data;
    logic [4:0]           o_sp_start_x;
    logic [4:0]           o_sp_start_y;
    logic [7:0]           o_sp_position_z;
    logic [3:0]           o_sp_row;
    modport master (
        output o_spr_addr, o_tex_req, o_tex_addr, o_sp_ena, o_sp_texture_data,
        output o_sp_start_x, o_sp_start_y, o_sp_position_z, o_sp_row,
        input  i_spr_data, i_tex_ack, i_tex_data
    );
    modport slave (
        input  o_spr_addr, o_tex_req, o_tex_addr, o_sp_ena, o_sp_texture_data,
        input  o_sp_start_x, o_sp_start_y, o_sp_position_z, o_sp_row,
        output i_spr_data, i_tex_ack, i_tex_data
    );
endinterface

// File: rtl/sprite_tile_scheduler.sv
// sprite_tile_scheduler: walks the sprite table, fetches 16 texture rows per sprite and broadcasts them, then a z=0 background pass.
// SPRITE_CULL_EN: when defined, sprites with x==0 or y==0 are skipped without fetching.
module sprite_tile_scheduler #(
    parameter int MAX_SPRITES = 16,
    parameter int SPR_AW      = 4,
    parameter int TEX_AW      = 12,
    parameter int ROWS        = 16,
    parameter int BG_TEX_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_frame_start,
    input  logic [SPR_AW:0]   i_sprite_count,
    output logic              o_busy,
    output logic              o_done,
    sprite_tile_scheduler_if.master bus
);
    localparam int RW = $clog2(ROWS);
    localparam logic [SPR_AW:0] MAXC = (SPR_AW+1)'(MAX_SPRITES);
    typedef enum logic [3:0] {IDLE, SPR_READ, SPR_WAIT, TEX_REQ, TEX_WAIT, ISSUE, BG_REQ, BG_WAIT, BG_ISSUE, DONE} state_t;
    state_t state_q, state_d, nxt_spr;
    logic [SPR_AW:0] cnt_q, cnt_d;
    logic [SPR_AW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d, orow_q, orow_d;
    logic [TEX_AW-1:0] base_q, base_d;
    logic [7:0] z_q, z_d, oz_q, oz_d;
    logic [4:0] x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d;
    logic [127:0] data_q, data_d;
    logic ena_q, ena_d, skip, last_spr, last_row, fetch, bg;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            ena_q   <= 1'b0;
            data_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            oz_q    <= '0;
            orow_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            base_q  <= base_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            ena_q   <= ena_d;
            data_q  <= data_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oz_q    <= oz_d;
            orow_q  <= orow_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        row_d    = row_q;
        base_d   = base_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        ena_d    = 1'b0;
        data_d   = data_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        oz_d     = oz_q;
        orow_d   = orow_q;
        bg       = state_q inside {BG_REQ, BG_WAIT};
        fetch    = bus.i_tex_ack && (state_q inside {TEX_REQ, TEX_WAIT, BG_REQ, BG_WAIT});
        last_row = row_q == RW'(ROWS-1);
        last_spr = (SPR_AW+1)'(idx_q) >= cnt_q - (SPR_AW+1)'(1);
        nxt_spr  = last_spr ? BG_REQ : SPR_READ;
`ifdef SPRITE_CULL_EN
        skip = bus.i_spr_data[17:10] == 8'd0 || bus.i_spr_data[4:0] == 5'd0 || bus.i_spr_data[9:5] == 5'd0;
`else
        skip = bus.i_spr_data[17:10] == 8'd0;
`endif
        // The beat registers load on the ack so they hold steady between beats.
        if (fetch) begin
            ena_d  = 1'b1;
            data_d = bus.i_tex_data;
            ox_d   = bg ? 5'd0 : x_q;
            oy_d   = bg ? 5'd0 : y_q;
            oz_d   = bg ? 8'd0 : z_q;
            orow_d = row_q;
        end
        case (state_q)
            IDLE: if (i_frame_start) begin
                cnt_d   = i_sprite_count > MAXC ? MAXC : i_sprite_count;
                idx_d   = '0;
                row_d   = '0;
                state_d = i_sprite_count == '0 ? BG_REQ : SPR_READ;
            end
            SPR_READ: state_d = SPR_WAIT;
            SPR_WAIT: begin
                {base_d, z_d, y_d, x_d} = bus.i_spr_data;
                state_d = skip ? nxt_spr : TEX_REQ;
                idx_d   = skip && !last_spr ? idx_q + 1'b1 : idx_q;
            end
            TEX_REQ, TEX_WAIT: state_d = fetch ? ISSUE : TEX_WAIT;
            ISSUE: begin
                row_d   = last_row ? '0 : row_q + 1'b1;
                state_d = last_row ? nxt_spr : TEX_REQ;
                idx_d   = last_row && !last_spr ? idx_q + 1'b1 : idx_q;
            end
            BG_REQ, BG_WAIT: state_d = fetch ? BG_ISSUE : BG_WAIT;
            BG_ISSUE: begin
                row_d   = last_row ? '0 : row_q + 1'b1;
                state_d = last_row ? DONE : BG_REQ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign o_busy                = !(state_q inside {IDLE, DONE});
    assign o_done                = state_q == DONE;
    assign bus.o_spr_addr        = idx_q;
    assign bus.o_tex_req         = state_q inside {TEX_REQ, TEX_WAIT, BG_REQ, BG_WAIT};
    assign bus.o_tex_addr        = (bg ? TEX_AW'(BG_TEX_BASE) : base_q) + TEX_AW'(row_q);
    assign bus.o_sp_ena          = ena_q;
    assign bus.o_sp_texture_data = data_q;
    assign bus.o_sp_start_x      = ox_q;
    assign bus.o_sp_start_y      = oy_q;
    assign bus.o_sp_position_z   = oz_q;
    assign bus.o_sp_row          = orow_q;
endmodule
